spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI slave front end for a single-port RAM. Deserialises 10-bit command words on MOSI into rx_data/rx_valid.
//  On a read-data command, serialises one RAM byte (tx_data/tx_valid) back out on MISO, MSB first.
//  Sits between the external SPI master and the RAM controller.
//  Single clock; SPI bit rate equals CLK, one bit per CLK.
// PARAMETERS
//  None. Fixed widths live in spi_pkg: RX_W=10 (cmd+payload word), TX_W=8 (read-back byte).
// PORTS
//  CLK       in   1   system/SPI clock; all state changes on rising edge
//  rst_n     in   1   reset, synchronous and active-high (1 = reset)
//  SS_n      in   1   slave select, active-low; high forces IDLE
//  MOSI      in   1   serial data from master, sampled on rising CLK
//  tx_valid  in   1   tx_data valid (RAM read data ready)
//  tx_data   in   8   byte to return on MISO
//  MISO      out  1   serial data to master
//  rx_valid  out  1   one-cycle pulse: rx_data holds a complete word
//  rx_data   out  10  received word {cmd[1:0], payload[7:0]}
// BEHAVIOUR
//  Reset (rst_n=1 at edge): state=IDLE, MISO=0, rx_valid=0, rx_data=0, counters=0, rd_addr_seen=0.
//  Commands (rx_data[9:8]):
//   - 00 = write address
//   - 01 = write data
//   - 10 = read address
//   - 11 = read data
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//  Any state, SS_n=1 at an edge -> IDLE next cycle.
//  IDLE -> CHK_CMD on the first edge with SS_n=0.
//  CHK_CMD: the sampled MOSI is word bit 9, shifted into the rx shift register.
//   - MOSI=0 -> WRITE
//   - MOSI=1 and rd_addr_seen=0 -> READ_ADD
//   - MOSI=1 and rd_addr_seen=1 -> READ_DATA
//  WRITE/READ_ADD/READ_DATA shift in the remaining 9 bits (bits 8..0), MSB first, one per edge.
//  After the 10th bit, rx_data is updated and rx_valid is high for exactly the following cycle.
//  rx_data holds its value until the next complete word. Latency: rx_valid rises 1 cycle after the last bit is sampled.
//  READ_ADD on completion: rd_addr_seen<=1.
//  READ_DATA, after its word completes: MOSI is ignored and the block waits for tx_valid.
//   - On the edge with tx_valid=1: latch tx_data, drive MISO=tx_data[7].
//   - The next 7 edges drive bits 6..0.
//   - Then MISO=0 and rd_addr_seen<=0.
//   - tx_valid in any other state/phase is ignored.
//  MISO=0 whenever not serialising. MISO is a registered output.
//  SS_n high mid-word: word discarded, no rx_valid, bit counter cleared; rd_addr_seen unchanged.
//  SS_n high mid-serialisation: MISO<=0, serialisation aborted, rd_addr_seen unchanged.
//  SS_n held low after a word completes: remain in state, ignore MOSI until SS_n rises.
//  Reset mid-operation overrides everything, same values as above.
// STRUCTURE
//  spi_pkg holds:
//   - state enum spi_state_e
//   - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
//   - RX_W, TX_W
//  One sub-module, spi_tx_serializer: 8-bit load/shift register + 3-bit counter driving MISO.
//  FSM, rx shift register, 4-bit bit counter and rd_addr_seen stay in spi_slave.
// TESTING
//  Reset: rst_n=1 for one edge -> MISO=0, rx_valid=0, rx_data=0.
//  Write address:
//   - Stimulus: SS_n=0, one idle cycle, MOSI=10'b00_1111_0000 MSB first.
//   - Response: rx_data=10'h0F0, single-cycle rx_valid.
//  Write data:
//   - Stimulus: same framing, 10'b01_1111_0000.
//   - Response: rx_data=10'h1F0, rx_valid pulse.
//  Read address then read data:
//   - Stimulus: 10'b10_1111_0000, SS_n high, then 10'b11_0000_0000.
//   - Response: rx_data=0x2F0 then 0x300, each with an rx_valid pulse.
//   - Stimulus: tx_valid=1, tx_data=8'hA5 for one cycle.
//   - Response: MISO=1,0,1,0,0,1,0,1 over the next 8 cycles, then 0.
//  Abort: raise SS_n after 5 bits -> no rx_valid; next full frame decodes correctly.
//  Second 1x frame after read data completes -> decoded as READ_ADD (rd_addr_seen cleared).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

    // Width of one received word: {cmd[1:0], payload[7:0]}
    localparam int RX_W = 10;
    // Width of the byte returned on MISO
    localparam int TX_W = 8;

    // Command codes carried in rx_data[9:8]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Slave FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// Loads one read-back byte and shifts it out MSB first on a registered MISO.
// MISO carries data[7] after the load edge, bits 6..0 on the next seven
// edges, then returns to 0 on the edge that also pulses done_o.
module spi_tx_serializer
    import spi_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [TX_W-1:0] data_i,
    input  logic            abort_i,
    output logic            miso_o,
    output logic            done_o
);

    logic [TX_W-1:0] shift_q, shift_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            active_q, active_d;
    logic            miso_q, miso_d;

    // Next-state: abort wins over load, load wins over shifting
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        miso_d   = miso_q;
        done_o   = active_q && (cnt_q == 3'd0) && !abort_i;
        if (abort_i) begin
            active_d = 1'b0;
            miso_d   = 1'b0;
            cnt_d    = 3'd0;
        end else if (load_i) begin
            shift_d  = {data_i[TX_W-2:0], 1'b0};
            miso_d   = data_i[TX_W-1];
            cnt_d    = 3'(TX_W - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q != 3'd0) begin
                miso_d  = shift_q[TX_W-1];
                shift_d = {shift_q[TX_W-2:0], 1'b0};
                cnt_d   = cnt_q - 3'd1;
            end else begin
                miso_d   = 1'b0;
                active_d = 1'b0;
            end
        end
    end

    // Register update with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            miso_q   <= miso_d;
        end
    end

    assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM: deserialises 10-bit command
// words from MOSI and, after a read-data command, returns one RAM byte on
// MISO. One bit per CLK; SS_n high returns to IDLE from any state.
//
// Handshake: rx_valid is a single-cycle pulse with no back-pressure; rx_data
// is stable whenever rx_valid is high and holds until the next complete word.
// tx_valid/tx_data are only consumed once, in READ_DATA after its word has
// completed; tx_valid at any other time is ignored.
module spi_slave
    import spi_pkg::*;
(
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            SS_n,
    input  logic            MOSI,
    input  logic            tx_valid,
    input  logic [TX_W-1:0] tx_data,
    output logic            MISO,
    output logic            rx_valid,
    output logic [RX_W-1:0] rx_data,
    output spi_state_e      dbg_state_o
);

    spi_state_e      state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [RX_W-2:0] shift_q, shift_d;
    logic [RX_W-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rd_seen_q, rd_seen_d;
    logic            word_done_q, word_done_d;
    logic            tx_started_q, tx_started_d;
    logic            tx_load;
    logic            tx_abort;
    logic            tx_done;

    // FSM next-state, shift register, counters and serializer control
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rd_seen_d    = rd_seen_q;
        word_done_d  = word_done_q;
        tx_started_d = tx_started_q;
        tx_load      = 1'b0;
        tx_abort     = 1'b0;
        if (SS_n) begin
            // Deselect discards any partial word or byte; rd_seen survives
            state_d      = ST_IDLE;
            bit_cnt_d    = 4'd0;
            word_done_d  = 1'b0;
            tx_started_d = 1'b0;
            tx_abort     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // First selected edge is a dead cycle; MOSI not sampled
                    state_d      = ST_CHK_CMD;
                    bit_cnt_d    = 4'd0;
                    shift_d      = '0;
                    word_done_d  = 1'b0;
                    tx_started_d = 1'b0;
                end
                ST_CHK_CMD: begin
                    // Word bit 9 picks write vs read; rd_seen picks read phase
                    shift_d   = {shift_q[RX_W-3:0], MOSI};
                    bit_cnt_d = 4'd1;
                    if (!MOSI) begin
                        state_d = ST_WRITE;
                    end else if (rd_seen_q) begin
                        state_d = ST_READ_DATA;
                    end else begin
                        state_d = ST_READ_ADD;
                    end
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (!word_done_q) begin
                        shift_d = {shift_q[RX_W-3:0], MOSI};
                        if (bit_cnt_q == 4'(RX_W - 1)) begin
                            rx_data_d   = {shift_q, MOSI};
                            rx_valid_d  = 1'b1;
                            word_done_d = 1'b1;
                            bit_cnt_d   = 4'd0;
                            if (state_q == ST_READ_ADD) begin
                                rd_seen_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if ((state_q == ST_READ_DATA) && !tx_started_q && tx_valid) begin
                        tx_load      = 1'b1;
                        tx_started_d = 1'b1;
                    end
                    if (tx_done) begin
                        rd_seen_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rd_seen_q    <= 1'b0;
            word_done_q  <= 1'b0;
            tx_started_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rd_seen_q    <= rd_seen_d;
            word_done_q  <= word_done_d;
            tx_started_q <= tx_started_d;
        end
    end

    spi_tx_serializer u_tx (
        .clk_i   (CLK),
        .rst_i   (rst_n),
        .load_i  (tx_load),
        .data_i  (tx_data),
        .abort_i (tx_abort),
        .miso_o  (MISO),
        .done_o  (tx_done)
    );

    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: framing, command decode, read-back
// serialisation, abort handling and reset.
module tb_spi_slave;
    import spi_pkg::*;

    logic            CLK;
    logic            rst_n;
    logic            SS_n;
    logic            MOSI;
    logic            tx_valid;
    logic [TX_W-1:0] tx_data;
    logic            MISO;
    logic            rx_valid;
    logic [RX_W-1:0] rx_data;
    spi_state_e      dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [RX_W-1:0] exp_q[$];

    spi_slave dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .SS_n        (SS_n),
        .MOSI        (MOSI),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .MISO        (MISO),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; outputs sampled 1ns later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full frame: one dead cycle then 10 bits MSB first, SS_n left low
    task automatic send_frame(input logic [RX_W-1:0] word, input string tag);
        int early;
        logic [RX_W-1:0] exp;
        early = 0;
        exp_q.push_back(word);
        SS_n = 1'b0;
        tick();
        if (rx_valid) early++;
        for (int i = RX_W - 1; i >= 0; i--) begin
            MOSI = word[i];
            tick();
            if (i > 0 && rx_valid) early++;
        end
        MOSI = 1'b0;
        exp = exp_q.pop_front();
        check_val({tag, "_early_valid"}, 16'(early), 16'd0);
        check_val({tag, "_valid"}, 16'(rx_valid), 16'd1);
        check_val({tag, "_data"}, 16'(rx_data), 16'(exp));
        tick();
        check_val({tag, "_pulse_end"}, 16'(rx_valid), 16'd0);
        check_val({tag, "_data_hold"}, 16'(rx_data), 16'(exp));
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        tick();
    endtask

    // Expect 8 bits of a loaded byte on MISO, then 0
    task automatic expect_byte(input logic [7:0] b, input string tag);
        logic [7:0] got;
        got = '0;
        for (int i = 7; i >= 0; i--) begin
            got[i] = MISO;
            if (i > 0) tick();
        end
        check_val({tag, "_miso_byte"}, 16'(got), 16'(b));
        tick();
        check_val({tag, "_miso_idle"}, 16'(MISO), 16'd0);
    endtask

    initial begin
        int vcount;
        rst_n    = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;

        // Reset
        tick();
        check_val("rst_miso", 16'(MISO), 16'd0);
        check_val("rst_rx_valid", 16'(rx_valid), 16'd0);
        check_val("rst_rx_data", 16'(rx_data), 16'd0);
        check_val("rst_state", 16'(dbg_state), 16'(ST_IDLE));
        rst_n = 1'b0;
        tick();

        // Write address
        send_frame(10'h0F0, "wr_addr");
        check_val("wr_addr_state", 16'(dbg_state), 16'(ST_WRITE));
        end_frame();
        check_val("idle_after_wr", 16'(dbg_state), 16'(ST_IDLE));

        // Write data, with tx_valid asserted throughout: must be ignored
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        send_frame(10'h1F0, "wr_data");
        tick();
        check_val("wr_data_tx_ignored", 16'(MISO), 16'd0);
        tx_valid = 1'b0;
        end_frame();

        // Read address then read data with read-back of 0xA5
        send_frame(10'h2F0, "rd_addr");
        check_val("rd_addr_state", 16'(dbg_state), 16'(ST_READ_ADD));
        end_frame();
        send_frame(10'h300, "rd_data");
        check_val("rd_data_state", 16'(dbg_state), 16'(ST_READ_DATA));
        tick();
        check_val("rd_data_miso_wait", 16'(MISO), 16'd0);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        expect_byte(8'hA5, "rd_a5");
        // A second tx_valid in the same selection is ignored
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tick();
        check_val("rd_second_tx_ignored", 16'(MISO), 16'd0);
        tx_valid = 1'b0;
        end_frame();

        // rd_seen cleared by completed read-back: 1x decodes as READ_ADD
        send_frame(10'h3C3, "rd_again");
        check_val("rd_again_state", 16'(dbg_state), 16'(ST_READ_ADD));
        end_frame();

        // Abort after 5 bits: no pulse, then a clean frame decodes
        SS_n = 1'b0;
        tick();
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'(i % 2);
            tick();
            if (rx_valid) vcount++;
        end
        SS_n = 1'b1;
        tick();
        if (rx_valid) vcount++;
        tick();
        if (rx_valid) vcount++;
        check_val("abort_no_valid", 16'(vcount), 16'd0);
        check_val("abort_state", 16'(dbg_state), 16'(ST_IDLE));
        check_val("abort_data_hold", 16'(rx_data), 16'h3C3);
        // rd_seen is still 1 from rd_again: this 1x frame is READ_DATA
        send_frame(10'h3AB, "after_abort");
        check_val("after_abort_state", 16'(dbg_state), 16'(ST_READ_DATA));

        // Abort mid-serialisation keeps rd_seen set
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_valid = 1'b0;
        check_val("ser_abort_bit7", 16'(MISO), 16'd1);
        tick();
        check_val("ser_abort_bit6", 16'(MISO), 16'd1);
        end_frame();
        check_val("ser_abort_miso", 16'(MISO), 16'd0);
        send_frame(10'h2AB, "rd_seen_kept");
        check_val("rd_seen_kept_state", 16'(dbg_state), 16'(ST_READ_DATA));
        end_frame();

        // Reset mid-frame
        SS_n = 1'b0;
        tick();
        MOSI = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_val("midrst_state", 16'(dbg_state), 16'(ST_IDLE));
        check_val("midrst_rx_data", 16'(rx_data), 16'd0);
        check_val("midrst_rx_valid", 16'(rx_valid), 16'd0);
        check_val("midrst_miso", 16'(MISO), 16'd0);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        tick();
        // rd_seen cleared by reset: 1x decodes as READ_ADD
        send_frame(10'h255, "post_rst");
        check_val("post_rst_state", 16'(dbg_state), 16'(ST_READ_ADD));
        end_frame();

        check_val("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
